// File: rtl/pipe_trace_buffer_if.sv
// Port bundle for the pipeline trace buffer: sampled channels, capture control,
// status flags and the valid/ready readout stream.
interface pipe_trace_buffer_if #(
  parameter int DATA_W   = 16,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 16,
  parameter int TS_W     = 8
);
  localparam int ENTRY_W = TS_W + CHANNELS + CHANNELS*DATA_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic [CHANNELS*DATA_W-1:0] ch_data;
  logic [CHANNELS-1:0]        ch_valid;
  logic                       stall;
  logic                       halt;
  logic                       cap_stalls;
  logic                       arm;
  logic                       abort;
  logic                       rd_start;
  logic                       rd_ready;
  logic                       rd_valid;
  logic [ENTRY_W-1:0]         rd_data;
  logic                       rd_last;
  logic                       done;
  logic [CNT_W-1:0]           count;
  logic                       wrapped;
  logic                       busy;

  modport master (
    output ch_data, ch_valid, stall, halt, cap_stalls, arm, abort, rd_start, rd_ready,
    input  rd_valid, rd_data, rd_last, done, count, wrapped, busy
  );

  modport slave (
    input  ch_data, ch_valid, stall, halt, cap_stalls, arm, abort, rd_start, rd_ready,
    output rd_valid, rd_data, rd_last, done, count, wrapped, busy
  );
endinterface

// File: rtl/pipe_trace_buffer.sv
// Circular trace capture of pipeline channels with post-trigger freeze and
// oldest-first valid/ready readout.
module pipe_trace_buffer #(
  parameter int DATA_W    = 16,
  parameter int CHANNELS  = 4,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 2,
  parameter int TS_W      = 8
) (
  input logic               clk,
  input logic               reset,
  pipe_trace_buffer_if.slave bus
);
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int ENTRY_W = TS_W + CHANNELS + CHANNELS*DATA_W;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [AW-1:0] POST_LOAD = AW'(POST_TRIG);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_POST, S_DONE, S_READ} state_t;

  state_t             state, state_n;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr, post_cnt;
  logic [CW-1:0]      count, rd_rem;
  logic               wrapped;
  logic [TS_W-1:0]    ts;
  logic [ENTRY_W-1:0] rd_data_p1;
  logic               vld_p1, last_p1;
  logic               done_r, busy_r;

  logic capturing, trig, cap, fire, start_arm, start_read, load, read_end;

  always_comb begin
    state_n    = state;
    capturing  = (state == S_ARMED) || (state == S_POST);
    trig       = (state == S_ARMED) && bus.halt;
    // The trigger sample is forced in even when the pipeline is stalled.
    cap        = capturing && !bus.abort && (!bus.stall || bus.cap_stalls || trig);
    fire       = vld_p1 && bus.rd_ready;
    start_arm  = 1'b0;
    start_read = 1'b0;
    load       = 1'b0;
    read_end   = 1'b0;
    if (bus.abort) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.arm) begin
            state_n   = S_ARMED;
            start_arm = 1'b1;
          end
        end
        S_ARMED: begin
          if (bus.halt) state_n = (POST_TRIG == 0) ? S_DONE : S_POST;
        end
        S_POST: begin
          if (cap && (post_cnt == AW'(1))) state_n = S_DONE;
        end
        S_DONE: begin
          if (bus.arm) begin
            state_n   = S_ARMED;
            start_arm = 1'b1;
          end else if (bus.rd_start) begin
            state_n    = S_READ;
            start_read = 1'b1;
          end
        end
        S_READ: begin
          if (fire && last_p1) begin
            state_n  = S_DONE;
            read_end = 1'b1;
          end else if (!vld_p1 || fire) begin
            load = 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      count      <= '0;
      wrapped    <= 1'b0;
      ts         <= '0;
      post_cnt   <= '0;
      rd_ptr     <= '0;
      rd_rem     <= '0;
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state  <= state_n;
      done_r <= (state_n == S_DONE) || (state_n == S_READ);
      busy_r <= (state_n == S_ARMED) || (state_n == S_POST);
      if (bus.abort) begin
        count   <= '0;
        wrapped <= 1'b0;
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
      end else if (start_arm) begin
        wr_ptr  <= '0;
        count   <= '0;
        wrapped <= 1'b0;
        ts      <= '0;
      end else begin
        if (capturing) ts <= ts + 1'b1;
        if (cap) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (count == FULL) wrapped <= 1'b1;
          else               count   <= count + 1'b1;
        end
        if (trig)                         post_cnt <= POST_LOAD;
        else if (cap && state == S_POST)  post_cnt <= post_cnt - 1'b1;
        // Once the buffer has wrapped, the oldest entry sits at the write pointer.
        if (start_read) begin
          rd_ptr <= wrapped ? wr_ptr : '0;
          rd_rem <= count;
        end
        // Read stage p1: registered output, held while the consumer stalls.
        if (read_end) begin
          vld_p1  <= 1'b0;
          last_p1 <= 1'b0;
        end else if (load) begin
          rd_data_p1 <= mem[rd_ptr];
          vld_p1     <= 1'b1;
          last_p1    <= (rd_rem == CW'(1));
          rd_ptr     <= rd_ptr + 1'b1;
          rd_rem     <= rd_rem - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cap) mem[wr_ptr] <= {ts, bus.ch_valid, bus.ch_data};
  end

  assign bus.rd_valid = vld_p1;
  assign bus.rd_data  = rd_data_p1;
  assign bus.rd_last  = last_p1;
  assign bus.done     = done_r;
  assign bus.busy     = busy_r;
  assign bus.count    = count;
  assign bus.wrapped  = wrapped;
endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed bench for pipe_trace_buffer: table-driven capture sequence plus
// hand-written sequences for wrap, stall, backpressure, abort and reset.
module tb_pipe_trace_buffer;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;
  int   since_arm = 0;
  logic [7:0] exp_ts [16];

  always #5 clk = ~clk;

  pipe_trace_buffer_if #(.DATA_W(16), .CHANNELS(4), .DEPTH(16), .TS_W(8)) bus ();

  pipe_trace_buffer #(.DATA_W(16), .CHANNELS(4), .DEPTH(16), .POST_TRIG(2), .TS_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       arm;
    logic       halt;
    logic       busy;
    logic       done;
    logic       wrapped;
    logic [4:0] count;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t mkv(logic a, logic h, logic b, logic d, logic w, logic [4:0] c);
    vec_t v;
    v.arm = a; v.halt = h; v.busy = b; v.done = d; v.wrapped = w; v.count = c;
    return v;
  endfunction

  function automatic logic [75:0] mk_entry(input logic [7:0] t);
    return {t, t[3:0], 16'hA5A5, 8'h01, t, 8'hFF, ~t, 8'h00, t};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Channel payload is derived from the cycle index since arm, which equals ts.
  task automatic step();
    logic [7:0] t;
    t = since_arm[7:0];
    bus.ch_data  = {16'hA5A5, 8'h01, t, 8'hFF, ~t, 8'h00, t};
    bus.ch_valid = t[3:0];
    @(posedge clk);
    #1;
    if (bus.arm && !bus.abort) since_arm = 0;
    else                       since_arm++;
  endtask

  task automatic read_check(input string tag, input int n, input int hold_at);
    bus.rd_start = 1'b1;
    bus.rd_ready = 1'b1;
    step();
    bus.rd_start = 1'b0;
    chk({tag, "_lat"}, bus.rd_valid, 0);
    step();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_vld[%0d]", tag, i), bus.rd_valid, 1);
      chk($sformatf("%s_data[%0d]", tag, i), bus.rd_data, mk_entry(exp_ts[i]));
      chk($sformatf("%s_last[%0d]", tag, i), bus.rd_last, (i == n-1));
      if (i == hold_at) begin
        bus.rd_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
          step();
          chk($sformatf("%s_hold_vld[%0d]", tag, j), bus.rd_valid, 1);
          chk($sformatf("%s_hold_data[%0d]", tag, j), bus.rd_data, mk_entry(exp_ts[i]));
          chk($sformatf("%s_hold_last[%0d]", tag, j), bus.rd_last, (i == n-1));
        end
        bus.rd_ready = 1'b1;
      end
      step();
    end
    chk({tag, "_end_vld"}, bus.rd_valid, 0);
    chk({tag, "_end_done"}, bus.done, 1);
  endtask

  task automatic chk_status(input string tag, input logic b, input logic d, input logic w, input logic [4:0] c);
    chk({tag, "_busy"}, bus.busy, b);
    chk({tag, "_done"}, bus.done, d);
    chk({tag, "_wrapped"}, bus.wrapped, w);
    chk({tag, "_count"}, bus.count, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mkv(1, 0, 1, 0, 0, 5'd0);
    tbl[1]  = mkv(0, 0, 1, 0, 0, 5'd1);
    tbl[2]  = mkv(0, 0, 1, 0, 0, 5'd2);
    tbl[3]  = mkv(0, 0, 1, 0, 0, 5'd3);
    tbl[4]  = mkv(0, 0, 1, 0, 0, 5'd4);
    tbl[5]  = mkv(0, 0, 1, 0, 0, 5'd5);
    tbl[6]  = mkv(0, 1, 1, 0, 0, 5'd6);
    tbl[7]  = mkv(0, 0, 1, 0, 0, 5'd7);
    tbl[8]  = mkv(0, 0, 0, 1, 0, 5'd8);
    tbl[9]  = mkv(0, 0, 0, 1, 0, 5'd8);
    tbl[10] = mkv(0, 1, 0, 1, 0, 5'd8);

    bus.ch_data = '0; bus.ch_valid = '0; bus.stall = 0; bus.halt = 0;
    bus.cap_stalls = 0; bus.arm = 0; bus.abort = 0; bus.rd_start = 0; bus.rd_ready = 1;
    reset = 1'b1;
    repeat (2) step();
    chk_status("rst", 0, 0, 0, 5'd0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_last", bus.rd_last, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    reset = 1'b0;
    step();

    // Basic capture: halt five cycles after arm, two post samples.
    for (int i = 0; i < 11; i++) begin
      bus.arm  = tbl[i].arm;
      bus.halt = tbl[i].halt;
      step();
      bus.arm  = 1'b0;
      bus.halt = 1'b0;
      chk_status($sformatf("t1[%0d]", i), tbl[i].busy, tbl[i].done, tbl[i].wrapped, tbl[i].count);
    end
    for (int i = 0; i < 8; i++) exp_ts[i] = 8'(i);
    read_check("t1", 8, -1);

    // Wrap-around: 40 clean cycles, halt at ts 40, oldest surviving entry is ts 27.
    bus.arm = 1'b1; step(); bus.arm = 1'b0;
    repeat (40) step();
    bus.halt = 1'b1; step(); bus.halt = 1'b0;
    repeat (2) step();
    chk_status("t2", 0, 1, 1, 5'd16);
    for (int i = 0; i < 16; i++) exp_ts[i] = 8'(27 + i);
    read_check("t2", 16, 5);
    read_check("t2r", 16, -1);

    // Stalls dropped; halt coincides with a stall; one stalled POST cycle.
    bus.cap_stalls = 1'b0;
    bus.arm = 1'b1; step(); bus.arm = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.stall = ((c >= 2) && (c <= 4)) || (c == 6) || (c == 7);
      bus.halt  = (c == 6);
      step();
      if (c == 7) chk_status("t3a_post_stall", 1, 0, 0, 5'd4);
    end
    bus.stall = 1'b0; bus.halt = 1'b0;
    chk_status("t3a", 0, 1, 0, 5'd6);
    exp_ts[0] = 8'd0; exp_ts[1] = 8'd1; exp_ts[2] = 8'd5;
    exp_ts[3] = 8'd6; exp_ts[4] = 8'd8; exp_ts[5] = 8'd9;
    read_check("t3a", 6, -1);

    // Stalled cycles captured when cap_stalls is set.
    bus.cap_stalls = 1'b1;
    bus.arm = 1'b1; step(); bus.arm = 1'b0;
    for (int c = 0; c < 9; c++) begin
      bus.stall = (c >= 2) && (c <= 4);
      bus.halt  = (c == 6);
      step();
    end
    bus.stall = 1'b0; bus.halt = 1'b0; bus.cap_stalls = 1'b0;
    chk_status("t3b", 0, 1, 0, 5'd9);
    for (int i = 0; i < 9; i++) exp_ts[i] = 8'(i);
    read_check("t3b", 9, -1);

    // Abort during POST.
    bus.arm = 1'b1; step(); bus.arm = 1'b0;
    repeat (2) step();
    bus.halt = 1'b1; step(); bus.halt = 1'b0;
    chk_status("t4_post", 1, 0, 0, 5'd3);
    bus.abort = 1'b1; step(); bus.abort = 1'b0;
    chk_status("t4_abort", 0, 0, 0, 5'd0);
    step();
    chk_status("t4_idle", 0, 0, 0, 5'd0);

    // Simultaneous arm and abort from DONE lands in IDLE.
    bus.arm = 1'b1; step(); bus.arm = 1'b0;
    bus.halt = 1'b1; step(); bus.halt = 1'b0;
    repeat (2) step();
    chk_status("t4_done", 0, 1, 0, 5'd3);
    bus.arm = 1'b1; bus.abort = 1'b1; step(); bus.arm = 1'b0; bus.abort = 1'b0;
    chk_status("t4_armabort", 0, 0, 0, 5'd0);
    step();
    chk_status("t4_armabort_idle", 0, 0, 0, 5'd0);

    // Reset while streaming, then a normal capture.
    bus.arm = 1'b1; step(); bus.arm = 1'b0;
    bus.halt = 1'b1; step(); bus.halt = 1'b0;
    repeat (2) step();
    bus.rd_start = 1'b1; bus.rd_ready = 1'b0; step(); bus.rd_start = 1'b0;
    step();
    chk("t5_pre_vld", bus.rd_valid, 1);
    reset = 1'b1; step(); reset = 1'b0; bus.rd_ready = 1'b1;
    chk_status("t5_rst", 0, 0, 0, 5'd0);
    chk("t5_rst_vld", bus.rd_valid, 0);
    chk("t5_rst_last", bus.rd_last, 0);
    chk("t5_rst_data", bus.rd_data, 0);
    bus.arm = 1'b1; step(); bus.arm = 1'b0;
    step();
    bus.halt = 1'b1; step(); bus.halt = 1'b0;
    repeat (2) step();
    chk_status("t5", 0, 1, 0, 5'd4);
    for (int i = 0; i < 4; i++) exp_ts[i] = 8'(i);
    read_check("t5", 4, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_trace_buffer.md
# pipe_trace_buffer

Synthesizable on-chip trace capture for the 5-stage microprocessor. Each cycle it samples a parametrised set of pipeline channels (for example IF PC, instruction, EX ALU result and WB write data) into a circular buffer. It freezes a configurable number of samples after `halt` and streams the captured history out oldest-first over a valid/ready port. It sits beside the datapath, is read-only toward the pipeline, and replaces per-cycle simulation printing with hardware-visible history.

## Interface
Parameters:
- `DATA_W`, 16: width of one channel.
- `CHANNELS`, 4: number of sampled channels (≥1).
- `DEPTH`, 16: entries; power of two, ≥2.
- `POST_TRIG`, 2: samples captured after the halt sample; 0..DEPTH-1.
- `TS_W`, 8: timestamp width.
- Derived `ENTRY_W` = TS_W + CHANNELS + CHANNELS*DATA_W.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ch_data` in CHANNELS*DATA_W: channel k at bits [k*DATA_W +: DATA_W].
- `ch_valid` in CHANNELS: per-channel valid, stored verbatim.
- `stall` in 1: pipeline stall; suppresses capture when `cap_stalls`=0.
- `halt` in 1: trigger.
- `cap_stalls` in 1: 1 = also capture stalled cycles; sampled every cycle.
- `arm` in 1: start capture.
- `abort` in 1: return to IDLE.
- `rd_start` in 1: begin readout.
- `rd_ready` in 1: consumer accepts `rd_data`.
- `rd_valid` out 1: `rd_data` is valid.
- `rd_data` out ENTRY_W: {timestamp, ch_valid, ch_data}, MSB first.
- `rd_last` out 1: qualifies the final entry.
- `done` out 1: capture frozen (high in DONE and READ).
- `count` out $clog2(DEPTH)+1: valid entries held, saturating at DEPTH.
- `wrapped` out 1: at least one entry was overwritten.
- `busy` out 1: in ARMED or POST.

## Operation
- States: IDLE, ARMED, POST, DONE, READ. On `reset`, enter IDLE; all outputs are 0, and the pointers, count, timestamp and post counter clear. Memory contents are don't-care.
- Capture strobe `cap` = (ARMED or POST) and (!stall or `cap_stalls` or halt-trigger cycle). The sample of the trigger cycle is always written.
- Each `cap` writes {ts, ch_valid, ch_data} at `wr_ptr`, increments `wr_ptr` modulo DEPTH, and increments `count`, saturating at DEPTH. `wrapped` sets on a write while `count`==DEPTH.
- `ts` is a TS_W counter. It clears on arm, increments every cycle in ARMED/POST (stalled or not), and wraps.
- IDLE or DONE + `arm` → ARMED. This clears `wr_ptr`, `count`, `wrapped` and `ts`.
- ARMED + `halt` → POST, loading post_cnt = POST_TRIG. If POST_TRIG==0, go straight to DONE.
- POST: each `cap` decrements post_cnt. The capture that makes it 0 → DONE. `halt` is ignored in POST.
- DONE + `rd_start` → READ. Read pointer = `wr_ptr` if `wrapped`, else 0. Entries remaining = `count`.
- READ:
  - `rd_data` is registered. `rd_valid` rises the cycle after entry into READ.
  - On `rd_valid && rd_ready`, the next entry is presented in the following cycle (one entry per cycle with ready held high).
  - `rd_data`, `rd_valid` and `rd_last` are held stable while `rd_valid && !rd_ready`.
  - `rd_last` is high with the final entry. Its acceptance → DONE with `rd_valid`=0. The buffer is unchanged, so readout can be repeated.
- `abort` in any state → IDLE next cycle; `count`/`wrapped` clear and `rd_valid` drops.
- Precedence: `reset` > `abort` > `arm`.
- Ignored inputs:
  - `arm` in ARMED, POST or READ.
  - `halt` in IDLE, DONE or READ.
  - `rd_start` outside DONE.
- DONE always holds `count` ≥ 1, because the trigger sample is forced.

## Timing
- Capture latency: a sample present at edge N is in memory after edge N. `count` updates at the same edge.
- `busy` and `done` are registered state decodes. `done` rises the cycle after the final capture.
- Readout latency: first `rd_valid` 2 cycles after the `rd_start` edge. Throughput is 1 entry/cycle.
- Wrap-around: with `count`==DEPTH, the oldest entry is at `wr_ptr`. The address arithmetic is modulo DEPTH.

## Test plan
- Defaults, `arm`, no stall; on cycle 5 after arm assert `halt` with ch0=0x0005 → after 2 more captures `done`=1, `count`=8, `wrapped`=0; readout gives 8 entries with ts 0..7, ch0 of entry 5 = 0x0005, and `rd_last` on the 8th.
- Run 40 unstalled cycles then `halt` → `count`=16, `wrapped`=1; readout starts at ts 27 and ends at ts 42 (halt at ts 40, plus 2 post samples), 16 entries in ascending order.
- `stall` high on cycles 2-4 with `cap_stalls`=0 → those cycles are absent and the ts sequence jumps 1→5. With `cap_stalls`=1 → all cycles present. A `halt` coinciding with `stall` is still captured.
- Readout backpressure: hold `rd_ready`=0 for 3 cycles mid-stream → `rd_data` is unchanged and no entry is skipped or duplicated. Repeat `rd_start` after DONE → identical stream.
- `abort` during POST → IDLE next cycle, `count`=0, `busy`=0. Same-cycle `arm`+`abort` from DONE → IDLE.
- `reset` asserted in READ with `rd_valid`=1 → next cycle all outputs 0, state IDLE; a subsequent `arm` captures normally.
